// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and types for the RV32IC fetch aligner
package fetch_pkg;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [1:0]  QUAD_32      = 2'b11;
    localparam logic [31:0] PC_INC_C     = 32'd2;
    localparam logic [31:0] PC_INC_W     = 32'd4;

    typedef logic [15:0] halfword_t;

    function automatic logic is_compr(input halfword_t h);
        return h[1:0] != QUAD_32;
    endfunction
endpackage

// File: rtl/fetch_hw_queue.sv
// fetch_hw_queue: 3-entry halfword shift queue, pop from head then append
module fetch_hw_queue
    import fetch_pkg::*;
(
    input  logic      Clk,
    input  logic      Reset,
    input  logic      flush,
    input  logic [1:0] push_n,
    input  halfword_t push_lo,
    input  halfword_t push_hi,
    input  logic [1:0] pop_n,
    output halfword_t q0,
    output halfword_t q1,
    output logic [1:0] count
);
    halfword_t  q_q [3];
    halfword_t  q_d [3];
    halfword_t  s [3];
    logic [1:0] count_q;
    logic [2:0] base;
    logic [2:0] count_d3;

    assign q0    = q_q[0];
    assign q1    = q_q[1];
    assign count = count_q;

    // shift survivors down by the pop amount, then place new halfwords behind them
    always_comb begin
        base     = {1'b0, count_q} - {1'b0, pop_n};
        count_d3 = base + {1'b0, push_n};
        s[0] = pop_n == 2'd2 ? q_q[2] : pop_n == 2'd1 ? q_q[1] : q_q[0];
        s[1] = pop_n == 2'd0 ? q_q[1] : pop_n == 2'd1 ? q_q[2] : '0;
        s[2] = pop_n == 2'd0 ? q_q[2] : '0;
        for (int i = 0; i < 3; i++)
            q_d[i] = (push_n != 2'd0 && 3'(i) == base) ? push_lo :
                     (push_n == 2'd2 && 3'(i) == base + 3'd1) ? push_hi : s[i];
    end

    // queue storage and occupancy; the request rule keeps occupancy within 3
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            count_q <= '0;
            q_q     <= '{default: '0};
        end else begin
            assert (flush || count_d3 <= 3'd3) else $error("fetch_hw_queue: overflow");
            count_q <= flush ? 2'd0 : count_d3[1:0];
            q_q     <= q_d;
        end
    end
endmodule

// File: rtl/fetch_aligner.sv
// fetch_aligner: word fetch sequencer and 16/32-bit instruction aligner
module fetch_aligner
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic        Clk,
    input  logic        Reset,
    output logic        Imem_Req,
    output logic [31:0] Imem_Addr,
    input  logic        Imem_Valid,
    input  logic [31:0] Imem_Rdata,
    input  logic        Redirect_Valid,
    input  logic [31:0] Redirect_Pc,
    input  logic        Inst_Ready,
    output logic        Inst_Valid,
    output logic [31:0] Inst_Raw,
    output logic [31:0] Inst_Pc,
    output logic [31:0] Inst_Pc_Next,
    output logic        Inst_Is_Compr
);
    halfword_t   q0, q1, push_lo;
    logic [1:0]  count, push_n, pop_n;
    logic        compr, resp, accept;
    logic [31:0] pc_q, pc_d, fetch_addr_q, fetch_addr_d;
    logic        outst_q, outst_d, kill_q, kill_d, drop_first_q, drop_first_d;
    logic        unused_ok;

    assign unused_ok = Redirect_Pc[0];

    fetch_hw_queue u_queue (
        .Clk     (Clk),
        .Reset   (Reset),
        .flush   (Redirect_Valid),
        .push_n  (push_n),
        .push_lo (push_lo),
        .push_hi (Imem_Rdata[31:16]),
        .pop_n   (pop_n),
        .q0      (q0),
        .q1      (q1),
        .count   (count)
    );

    // instruction extraction, fetch issue and next-state selection; redirect wins
    always_comb begin
        compr         = is_compr(q0);
        Inst_Valid    = count != 2'd0 && (compr || count >= 2'd2);
        Inst_Raw      = !Inst_Valid ? 32'h0 : compr ? {16'h0, q0} : {q1, q0};
        Inst_Is_Compr = Inst_Raw[1:0] != QUAD_32;
        Inst_Pc       = pc_q;
        Inst_Pc_Next  = pc_q + (compr ? PC_INC_C : PC_INC_W);
        Imem_Req      = !Reset && !outst_q && count <= 2'd1 && !Redirect_Valid;
        Imem_Addr     = fetch_addr_q;
        resp          = Imem_Valid && outst_q;
        accept        = Inst_Valid && Inst_Ready && !Redirect_Valid;
        pop_n         = accept ? (compr ? 2'd1 : 2'd2) : 2'd0;
        push_n        = (resp && !kill_q && !Redirect_Valid) ? (drop_first_q ? 2'd1 : 2'd2) : 2'd0;
        push_lo       = drop_first_q ? Imem_Rdata[31:16] : Imem_Rdata[15:0];
        pc_d          = Redirect_Valid ? {Redirect_Pc[31:1], 1'b0} : accept ? Inst_Pc_Next : pc_q;
        fetch_addr_d  = Redirect_Valid ? {Redirect_Pc[31:2], 2'b00} :
                        Imem_Req ? fetch_addr_q + 32'd4 : fetch_addr_q;
        outst_d       = Redirect_Valid ? outst_q && !Imem_Valid : Imem_Req || (outst_q && !Imem_Valid);
        kill_d        = Redirect_Valid ? outst_q && !Imem_Valid : kill_q && !resp;
        drop_first_d  = Redirect_Valid ? Redirect_Pc[1] : drop_first_q && !(resp && !kill_q);
    end

    // fetch control and PC registers
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            pc_q         <= {RESET_PC[31:1], 1'b0};
            fetch_addr_q <= {RESET_PC[31:2], 2'b00};
            outst_q      <= 1'b0;
            kill_q       <= 1'b0;
            drop_first_q <= RESET_PC[1];
        end else begin
            pc_q         <= pc_d;
            fetch_addr_q <= fetch_addr_d;
            outst_q      <= outst_d;
            kill_q       <= kill_d;
            drop_first_q <= drop_first_d;
        end
    end
endmodule

// File: tb/tb_fetch_aligner.sv
// tb_fetch_aligner: directed checks of fetch, alignment, redirect, backpressure and reset
module tb_fetch_aligner;
    logic        Clk, Reset, Imem_Req, Imem_Valid, Redirect_Valid, Inst_Ready, Inst_Valid, Inst_Is_Compr;
    logic [31:0] Imem_Addr, Imem_Rdata, Redirect_Pc, Inst_Raw, Inst_Pc, Inst_Pc_Next;

    int n_cmp = 0, n_mis = 0;
    int lat = 1, wcnt = 0, cyc = 0, dup = 0;
    logic pend = 0;
    logic [31:0] paddr = 0, m0 = 0, m4 = 0;
    logic [31:0] reqs[$], acc_pc[$], acc_raw[$], acc_nx[$];
    logic acc_cmp[$];
    int acc_cyc[$];

    fetch_aligner #(.RESET_PC(32'h0)) dut (
        .Clk(Clk), .Reset(Reset), .Imem_Req(Imem_Req), .Imem_Addr(Imem_Addr),
        .Imem_Valid(Imem_Valid), .Imem_Rdata(Imem_Rdata), .Redirect_Valid(Redirect_Valid),
        .Redirect_Pc(Redirect_Pc), .Inst_Ready(Inst_Ready), .Inst_Valid(Inst_Valid),
        .Inst_Raw(Inst_Raw), .Inst_Pc(Inst_Pc), .Inst_Pc_Next(Inst_Pc_Next),
        .Inst_Is_Compr(Inst_Is_Compr)
    );

    initial begin
        Clk = 0;
        forever #5 Clk = ~Clk;
    end

    function automatic logic [31:0] word(input logic [31:0] a);
        return a == 32'h0 ? m0 : a == 32'h4 ? m4 : a == 32'h100 ? 32'h4505_4501 : 32'h0001_0001;
    endfunction

    // memory model: answers the single outstanding request after lat cycles
    always @(negedge Clk) begin
        Imem_Valid = 0;
        if (pend) begin
            wcnt--;
            if (wcnt == 0) begin
                Imem_Valid = 1;
                Imem_Rdata = word(paddr);
                pend = 0;
            end
        end
    end

    // monitor just before each rising edge: requests and accepted instructions
    always @(negedge Clk) begin
        #4;
        if (Reset) cyc = 0;
        else begin
            if (Imem_Req) begin
                if (pend) dup++;
                pend = 1; paddr = Imem_Addr; wcnt = lat;
                reqs.push_back(Imem_Addr);
            end
            if (Inst_Valid && Inst_Ready && !Redirect_Valid) begin
                acc_pc.push_back(Inst_Pc); acc_raw.push_back(Inst_Raw);
                acc_nx.push_back(Inst_Pc_Next); acc_cmp.push_back(Inst_Is_Compr);
                acc_cyc.push_back(cyc);
            end
            cyc++;
        end
    end

    task automatic clear_logs();
        reqs.delete(); acc_pc.delete(); acc_raw.delete(); acc_nx.delete();
        acc_cmp.delete(); acc_cyc.delete(); dup = 0;
    endtask

    task automatic start(input int l);
        @(negedge Clk);
        Reset = 1; Redirect_Valid = 0; Inst_Ready = 1; lat = l;
        repeat (6) @(negedge Clk);
        clear_logs();
        Reset = 0;
    endtask

    task automatic test_reset();
        lat = 1;
        @(negedge Clk);
        Reset = 1;
        #1;
        n_cmp++; if (Imem_Req !== 1'b0) begin n_mis++; $display("FAIL rst_req got %0b want 0", Imem_Req); end
        n_cmp++; if (Inst_Valid !== 1'b0) begin n_mis++; $display("FAIL rst_valid got %0b want 0", Inst_Valid); end
        n_cmp++; if (Inst_Raw !== 32'h0) begin n_mis++; $display("FAIL rst_raw got %h want 0", Inst_Raw); end
        repeat (3) @(negedge Clk);
        Reset = 0;
        #4;
        n_cmp++; if (Imem_Req !== 1'b1) begin n_mis++; $display("FAIL first_req got %0b want 1", Imem_Req); end
        n_cmp++; if (Imem_Addr !== 32'h0) begin n_mis++; $display("FAIL first_addr got %h want 0", Imem_Addr); end
        n_cmp++; if (Inst_Pc !== 32'h0) begin n_mis++; $display("FAIL rst_pc got %h want 0", Inst_Pc); end
    endtask

    task automatic test_basic();
        logic [31:0] e_pc [3] = '{32'h0, 32'h4, 32'h6};
        logic [31:0] e_raw[3] = '{32'h00A0_0093, 32'h0000_4501, 32'h0000_4505};
        logic [31:0] e_nx [3] = '{32'h4, 32'h6, 32'h8};
        logic        e_cmp[3] = '{1'b0, 1'b1, 1'b1};
        int          e_cyc[3] = '{2, 5, 6};
        m0 = 32'h00A0_0093; m4 = 32'h4505_4501;
        start(1);
        repeat (12) @(negedge Clk);
        n_cmp++; if (acc_pc.size() < 3) begin n_mis++; $display("FAIL basic_count got %0d want >=3", acc_pc.size()); end
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (acc_pc[i] !== e_pc[i]) begin n_mis++; $display("FAIL basic_pc[%0d] got %h want %h", i, acc_pc[i], e_pc[i]); end
            n_cmp++; if (acc_raw[i] !== e_raw[i]) begin n_mis++; $display("FAIL basic_raw[%0d] got %h want %h", i, acc_raw[i], e_raw[i]); end
            n_cmp++; if (acc_nx[i] !== e_nx[i]) begin n_mis++; $display("FAIL basic_next[%0d] got %h want %h", i, acc_nx[i], e_nx[i]); end
            n_cmp++; if (acc_cmp[i] !== e_cmp[i]) begin n_mis++; $display("FAIL basic_compr[%0d] got %0b want %0b", i, acc_cmp[i], e_cmp[i]); end
            n_cmp++; if (acc_cyc[i] != e_cyc[i]) begin n_mis++; $display("FAIL basic_cycle[%0d] got %0d want %0d", i, acc_cyc[i], e_cyc[i]); end
        end
    endtask

    task automatic test_spanning();
        logic [31:0] e_pc [3] = '{32'h0, 32'h2, 32'h6};
        logic [31:0] e_raw[3] = '{32'h0000_4501, 32'h00A0_0093, 32'h0000_4505};
        logic [31:0] e_nx [3] = '{32'h2, 32'h6, 32'h8};
        int          e_cyc[3] = '{2, 5, 6};
        m0 = 32'h0093_4501; m4 = 32'h4505_00A0;
        start(1);
        repeat (12) @(negedge Clk);
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (acc_pc[i] !== e_pc[i]) begin n_mis++; $display("FAIL span_pc[%0d] got %h want %h", i, acc_pc[i], e_pc[i]); end
            n_cmp++; if (acc_raw[i] !== e_raw[i]) begin n_mis++; $display("FAIL span_raw[%0d] got %h want %h", i, acc_raw[i], e_raw[i]); end
            n_cmp++; if (acc_nx[i] !== e_nx[i]) begin n_mis++; $display("FAIL span_next[%0d] got %h want %h", i, acc_nx[i], e_nx[i]); end
            n_cmp++; if (acc_cyc[i] != e_cyc[i]) begin n_mis++; $display("FAIL span_cycle[%0d] got %0d want %0d", i, acc_cyc[i], e_cyc[i]); end
        end
    endtask

    task automatic test_redirect_kill();
        m0 = 32'h00A0_0093; m4 = 32'h4505_4501;
        start(3);
        @(negedge Clk);
        Redirect_Valid = 1; Redirect_Pc = 32'h102;
        #4;
        n_cmp++; if (Imem_Req !== 1'b0) begin n_mis++; $display("FAIL redir_req got %0b want 0", Imem_Req); end
        @(negedge Clk);
        Redirect_Valid = 0;
        clear_logs();
        repeat (20) @(negedge Clk);
        n_cmp++; if (reqs[0] !== 32'h100) begin n_mis++; $display("FAIL redir_addr got %h want 100", reqs[0]); end
        n_cmp++; if (acc_pc[0] !== 32'h102) begin n_mis++; $display("FAIL redir_pc got %h want 102", acc_pc[0]); end
        n_cmp++; if (acc_raw[0] !== 32'h0000_4505) begin n_mis++; $display("FAIL redir_raw got %h want 00004505", acc_raw[0]); end
        n_cmp++; if (acc_nx[0] !== 32'h104) begin n_mis++; $display("FAIL redir_next got %h want 104", acc_nx[0]); end
        n_cmp++; if (acc_cyc[0] != 8) begin n_mis++; $display("FAIL redir_cycle got %0d want 8", acc_cyc[0]); end
        n_cmp++; if (acc_pc[1] !== 32'h104) begin n_mis++; $display("FAIL redir_pc2 got %h want 104", acc_pc[1]); end
        n_cmp++; if (acc_raw[1] !== 32'h0000_0001) begin n_mis++; $display("FAIL redir_raw2 got %h want 00000001", acc_raw[1]); end
    endtask

    task automatic test_redirect_latency();
        m0 = 32'h00A0_0093; m4 = 32'h4505_4501;
        start(1);
        Inst_Ready = 0;
        repeat (10) @(negedge Clk);
        Redirect_Valid = 1; Redirect_Pc = 32'h201;
        #4;
        n_cmp++; if (Imem_Req !== 1'b0) begin n_mis++; $display("FAIL lat_n_req got %0b want 0", Imem_Req); end
        @(negedge Clk);
        Redirect_Valid = 0;
        #4;
        n_cmp++; if (Imem_Req !== 1'b1) begin n_mis++; $display("FAIL lat_n1_req got %0b want 1", Imem_Req); end
        n_cmp++; if (Imem_Addr !== 32'h200) begin n_mis++; $display("FAIL lat_n1_addr got %h want 200", Imem_Addr); end
        n_cmp++; if (Inst_Valid !== 1'b0) begin n_mis++; $display("FAIL lat_n1_valid got %0b want 0", Inst_Valid); end
        @(negedge Clk); #4;
        n_cmp++; if (Inst_Valid !== 1'b0) begin n_mis++; $display("FAIL lat_n2_valid got %0b want 0", Inst_Valid); end
        @(negedge Clk); #4;
        n_cmp++; if (Inst_Valid !== 1'b1) begin n_mis++; $display("FAIL lat_n3_valid got %0b want 1", Inst_Valid); end
        n_cmp++; if (Inst_Pc !== 32'h200) begin n_mis++; $display("FAIL lat_n3_pc got %h want 200", Inst_Pc); end
        n_cmp++; if (Inst_Raw !== 32'h1) begin n_mis++; $display("FAIL lat_n3_raw got %h want 00000001", Inst_Raw); end
        Inst_Ready = 1;
    endtask

    task automatic test_backpressure();
        logic [31:0] e_pc [3] = '{32'h0, 32'h4, 32'h6};
        logic [31:0] e_raw[3] = '{32'h00A0_0093, 32'h0000_4501, 32'h0000_4505};
        m0 = 32'h00A0_0093; m4 = 32'h4505_4501;
        start(1);
        Inst_Ready = 0;
        repeat (2) @(negedge Clk);
        for (int i = 0; i < 5; i++) begin
            #4;
            n_cmp++; if (Inst_Valid !== 1'b1) begin n_mis++; $display("FAIL bp_valid[%0d] got %0b want 1", i, Inst_Valid); end
            n_cmp++; if (Inst_Raw !== 32'h00A0_0093) begin n_mis++; $display("FAIL bp_raw[%0d] got %h want 00a00093", i, Inst_Raw); end
            n_cmp++; if (Inst_Pc !== 32'h0) begin n_mis++; $display("FAIL bp_pc[%0d] got %h want 0", i, Inst_Pc); end
            n_cmp++; if (Imem_Req !== 1'b0) begin n_mis++; $display("FAIL bp_req[%0d] got %0b want 0", i, Imem_Req); end
            @(negedge Clk);
        end
        Inst_Ready = 1;
        repeat (12) @(negedge Clk);
        n_cmp++; if (acc_cyc[0] != 7) begin n_mis++; $display("FAIL bp_cycle got %0d want 7", acc_cyc[0]); end
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (acc_pc[i] !== e_pc[i]) begin n_mis++; $display("FAIL bp_order_pc[%0d] got %h want %h", i, acc_pc[i], e_pc[i]); end
            n_cmp++; if (acc_raw[i] !== e_raw[i]) begin n_mis++; $display("FAIL bp_order_raw[%0d] got %h want %h", i, acc_raw[i], e_raw[i]); end
        end
    endtask

    task automatic test_slow_memory();
        logic [31:0] e_pc [3] = '{32'h0, 32'h4, 32'h6};
        logic [31:0] e_raw[3] = '{32'h00A0_0093, 32'h0000_4501, 32'h0000_4505};
        int          e_cyc[3] = '{4, 9, 10};
        logic [31:0] e_req[3] = '{32'h0, 32'h4, 32'h8};
        m0 = 32'h00A0_0093; m4 = 32'h4505_4501;
        start(3);
        repeat (25) @(negedge Clk);
        n_cmp++; if (dup != 0) begin n_mis++; $display("FAIL slow_inflight got %0d extra want 0", dup); end
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (reqs[i] !== e_req[i]) begin n_mis++; $display("FAIL slow_addr[%0d] got %h want %h", i, reqs[i], e_req[i]); end
            n_cmp++; if (acc_pc[i] !== e_pc[i]) begin n_mis++; $display("FAIL slow_pc[%0d] got %h want %h", i, acc_pc[i], e_pc[i]); end
            n_cmp++; if (acc_raw[i] !== e_raw[i]) begin n_mis++; $display("FAIL slow_raw[%0d] got %h want %h", i, acc_raw[i], e_raw[i]); end
            n_cmp++; if (acc_cyc[i] != e_cyc[i]) begin n_mis++; $display("FAIL slow_cycle[%0d] got %0d want %0d", i, acc_cyc[i], e_cyc[i]); end
        end
    endtask

    task automatic test_reset_midstream();
        logic [31:0] e_pc [3] = '{32'h0, 32'h2, 32'h4};
        logic [31:0] e_raw[3] = '{32'h0000_4501, 32'h0000_4505, 32'h00A0_0093};
        m0 = 32'h4505_4501; m4 = 32'h00A0_0093;
        start(3);
        repeat (5) @(negedge Clk);
        Inst_Ready = 0;
        @(negedge Clk); #4;
        n_cmp++; if (Inst_Valid !== 1'b1) begin n_mis++; $display("FAIL mid_pre_valid got %0b want 1", Inst_Valid); end
        n_cmp++; if (Inst_Pc !== 32'h2) begin n_mis++; $display("FAIL mid_pre_pc got %h want 2", Inst_Pc); end
        @(negedge Clk);
        Reset = 1;
        #1;
        n_cmp++; if (Inst_Valid !== 1'b0) begin n_mis++; $display("FAIL mid_rst_valid got %0b want 0", Inst_Valid); end
        n_cmp++; if (Inst_Raw !== 32'h0) begin n_mis++; $display("FAIL mid_rst_raw got %h want 0", Inst_Raw); end
        n_cmp++; if (Inst_Pc !== 32'h0) begin n_mis++; $display("FAIL mid_rst_pc got %h want 0", Inst_Pc); end
        n_cmp++; if (Imem_Req !== 1'b0) begin n_mis++; $display("FAIL mid_rst_req got %0b want 0", Imem_Req); end
        repeat (3) @(negedge Clk);
        clear_logs();
        Reset = 0; Inst_Ready = 1;
        repeat (14) @(negedge Clk);
        n_cmp++; if (reqs[0] !== 32'h0) begin n_mis++; $display("FAIL mid_restart_addr got %h want 0", reqs[0]); end
        n_cmp++; if (acc_cyc[0] != 4) begin n_mis++; $display("FAIL mid_restart_cycle got %0d want 4", acc_cyc[0]); end
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (acc_pc[i] !== e_pc[i]) begin n_mis++; $display("FAIL mid_pc[%0d] got %h want %h", i, acc_pc[i], e_pc[i]); end
            n_cmp++; if (acc_raw[i] !== e_raw[i]) begin n_mis++; $display("FAIL mid_raw[%0d] got %h want %h", i, acc_raw[i], e_raw[i]); end
        end
    endtask

    initial begin
        Reset = 1; Imem_Valid = 0; Imem_Rdata = 0; Redirect_Valid = 0; Redirect_Pc = 0; Inst_Ready = 1;
        test_reset();
        test_basic();
        test_spanning();
        test_redirect_kill();
        test_redirect_latency();
        test_backpressure();
        test_slow_memory();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
